branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor: a direct-mapped BTB with a 2-bit saturating counter per entry.
- It produces the taken/not-taken prediction and target for PCF.
- It is trained from the Execute stage once a branch or jump resolves. The resolution is the Actual/Predicted comparison performed by the EX-stage prediction handler.
- It also keeps saturating performance counters for resolved control-transfers and mispredictions.

---
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained from Execute, plus saturating perf counters.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  PCF,
  output logic                 PredictTakenF,
  output logic [PC_WIDTH-1:0]  PredTargetF,
  input  logic                 update_en,
  input  logic [PC_WIDTH-1:0]  PCE,
  input  logic                 is_jump,
  input  logic                 ActualTaken,
  input  logic [PC_WIDTH-1:0]  TargetE,
  input  logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;

  logic                valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [PC_WIDTH-1:0] target_reg [ENTRIES];
  logic [1:0]          ctr_reg    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;

  logic                  wr_en;
  logic                  valid_next;
  logic [TAG_BITS-1:0]   tag_next;
  logic [PC_WIDTH-1:0]   target_next;
  logic [1:0]            ctr_next;

  logic [CNT_WIDTH-1:0]  branch_count_reg, mispredict_count_reg;

  // Instruction-alignment bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[PC_WIDTH-1:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[PC_WIDTH-1:INDEX_BITS+2];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign hit_f         = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);
  assign PredictTakenF = hit_f && ctr_reg[idx_f][1];
  assign PredTargetF   = PredictTakenF ? target_reg[idx_f] : '0;

  assign hit_e = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);

  always_comb begin
    wr_en       = 1'b0;
    valid_next  = valid_reg[idx_e];
    tag_next    = tag_reg[idx_e];
    target_next = target_reg[idx_e];
    ctr_next    = ctr_reg[idx_e];
    if (update_en) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (is_jump) begin
          ctr_next    = 2'b11;
          target_next = TargetE;
        end else if (ActualTaken) begin
          ctr_next    = (ctr_reg[idx_e] == 2'b11) ? 2'b11 : ctr_reg[idx_e] + 2'd1;
          target_next = TargetE;
        end else begin
          ctr_next    = (ctr_reg[idx_e] == 2'b00) ? 2'b00 : ctr_reg[idx_e] - 2'd1;
        end
      end else if (ActualTaken || is_jump) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        wr_en       = 1'b1;
        valid_next  = 1'b1;
        tag_next    = tag_e;
        target_next = TargetE;
        ctr_next    = is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi]  <= 1'b0;
          tag_reg[gi]    <= '0;
          target_reg[gi] <= '0;
          ctr_reg[gi]    <= 2'b01;
        end else if (wr_en && (idx_e == INDEX_BITS'(gi))) begin
          valid_reg[gi]  <= valid_next;
          tag_reg[gi]    <= tag_next;
          target_reg[gi] <= target_next;
          ctr_reg[gi]    <= ctr_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else if (update_en) begin
      if (branch_count_reg != '1)
        branch_count_reg <= branch_count_reg + 1'b1;
      if (mispredict && (mispredict_count_reg != '1))
        mispredict_count_reg <= mispredict_count_reg + 1'b1;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a default build plus a CNT_WIDTH=4 build
// sharing the same stimulus to exercise counter saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PCE, TargetE;
  logic        update_en, is_jump, ActualTaken, mispredict;

  logic        pt_big, pt_small;
  logic [31:0] ptgt_big, ptgt_small;
  logic [31:0] bc_big, mc_big;
  logic [3:0]  bc_small, mc_small;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(4), .PC_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .PCF(PCF),
    .PredictTakenF(pt_big), .PredTargetF(ptgt_big),
    .update_en(update_en), .PCE(PCE), .is_jump(is_jump),
    .ActualTaken(ActualTaken), .TargetE(TargetE), .mispredict(mispredict),
    .branch_count(bc_big), .mispredict_count(mc_big)
  );

  branch_predictor #(.INDEX_BITS(4), .PC_WIDTH(32), .CNT_WIDTH(4)) u_small (
    .clk(clk), .reset(reset), .PCF(PCF),
    .PredictTakenF(pt_small), .PredTargetF(ptgt_small),
    .update_en(update_en), .PCE(PCE), .is_jump(is_jump),
    .ActualTaken(ActualTaken), .TargetE(TargetE), .mispredict(mispredict),
    .branch_count(bc_small), .mispredict_count(mc_small)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic jmp, input logic taken,
                     input logic [31:0] tgt, input logic mis);
    update_en   = 1'b1;
    PCE         = pc;
    is_jump     = jmp;
    ActualTaken = taken;
    TargetE     = tgt;
    mispredict  = mis;
    $display("update pc=0x%08h jump=%0b taken=%0b target=0x%08h mis=%0b", pc, jmp, taken, tgt, mis);
    tick();
    update_en = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input string tag,
                      input logic exp_t, input logic [31:0] exp_tgt);
    PCF = pc;
    #1;
    $display("lookup pc=0x%08h taken=%0b target=0x%08h", pc, pt_big, ptgt_big);
    check_val({tag, "_taken"}, {31'd0, pt_big}, {31'd0, exp_t});
    check_val({tag, "_target"}, ptgt_big, exp_tgt);
  endtask

  initial begin
    reset = 1'b1; PCF = 32'h40; PCE = '0; TargetE = '0;
    update_en = 1'b0; is_jump = 1'b0; ActualTaken = 1'b0; mispredict = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    look(32'h40, "rst", 1'b0, 32'h0);
    check_val("rst_bc", bc_big, 32'd0);
    check_val("rst_mc", mc_big, 32'd0);

    // First taken allocation -> weak-T
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1);
    look(32'h40, "alloc", 1'b1, 32'h100);
    check_val("alloc_bc", bc_big, 32'd1);
    check_val("alloc_mc", mc_big, 32'd1);

    // Hysteresis: 10 -> 01 -> 10 -> 11 (sat) -> 10
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
    look(32'h40, "hyst_nt", 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1);
    look(32'h40, "hyst_t", 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
    look(32'h40, "hyst_sat", 1'b1, 32'h100);
    check_val("hyst_bc", bc_big, 32'd7);
    check_val("hyst_mc", mc_big, 32'd4);

    // Jump allocates strong-T; one NT leaves it predicting taken
    upd(32'h44, 1'b1, 1'b1, 32'h200, 1'b1);
    look(32'h44, "jump", 1'b1, 32'h200);
    upd(32'h44, 1'b0, 1'b0, 32'h0, 1'b1);
    look(32'h44, "jump_nt", 1'b1, 32'h200);

    // Aliasing on index 1 evicts 0x44; index 0 untouched
    upd(32'h84, 1'b0, 1'b1, 32'h300, 1'b1);
    look(32'h44, "alias_old", 1'b0, 32'h0);
    look(32'h84, "alias_new", 1'b1, 32'h300);
    look(32'h40, "alias_other", 1'b1, 32'h100);
    check_val("alias_bc", bc_big, 32'd10);
    check_val("alias_mc", mc_big, 32'd7);

    // Reset together with an update: update discarded, all state cleared
    reset = 1'b1;
    upd(32'h40, 1'b0, 1'b1, 32'h500, 1'b1);
    reset = 1'b0;
    look(32'h40, "midrst_40", 1'b0, 32'h0);
    look(32'h84, "midrst_84", 1'b0, 32'h0);
    check_val("midrst_bc", bc_big, 32'd0);
    check_val("midrst_mc", mc_big, 32'd0);

    // Same-cycle read/write: pre-update contents, then new state
    PCF = 32'h40;
    update_en = 1'b1; PCE = 32'h40; is_jump = 1'b0; ActualTaken = 1'b1;
    TargetE = 32'h140; mispredict = 1'b1;
    #1;
    $display("update pc=0x00000040 with same-cycle lookup taken=%0b", pt_big);
    check_val("rdw_same", {31'd0, pt_big}, 32'd0);
    tick();
    update_en = 1'b0;
    look(32'h40, "rdw_next", 1'b1, 32'h140);

    // Tag mismatch on same index, and not-taken miss leaves table alone
    look(32'h80, "tag_miss", 1'b0, 32'h0);
    upd(32'h48, 1'b0, 1'b0, 32'h999, 1'b0);
    look(32'h48, "nt_miss", 1'b0, 32'h0);

    // Saturation: 20 updates after reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 20; i++) upd(32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b1);
    check_val("sat_bc_big", bc_big, 32'd20);
    check_val("sat_mc_big", mc_big, 32'd20);
    check_val("sat_bc_small", {28'd0, bc_small}, 32'hF);
    check_val("sat_mc_small", {28'd0, mc_small}, 32'hF);
    check_val("small_pt", {31'd0, pt_small}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
